spi_aes_frame_master: RTL

- Parametrised SPI master that ships one AES job (data block, then key of 128/192/256 bits) to one of N_SLAVES SPI AES cores.
- It waits a fixed turnaround, then shifts back a DATA_W-bit result.
- Replaces hard-wired two-slave, free-running sequencing with an explicit start/busy/done handshake, per-job slave select, a programmable SCLK divider and error reporting.
- Sits between the top-level control logic and the SPI slave cores.

---
 rtl/spi_aes_pkg.sv | 25 ++
 rtl/spi_sclk_gen.sv | 38 +++
 rtl/spi_aes_frame_master.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/spi_aes_pkg.sv
// rtl/spi_aes_pkg.sv - shared states, key width and key-length decode for the SPI AES frame master
package spi_aes_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SEND_DATA,
    SEND_KEY,
    WAIT,
    RECV,
    DONE
  } state_t;

  localparam int KEY_W = 256;

  // 00 -> Nk 4, 01 -> Nk 6, 10/11 -> Nk 8; returns 32*Nk
  function automatic logic [8:0] nk_bits(input logic [1:0] key_len);
    case (key_len)
      2'b00:   return 9'd128;
      2'b01:   return 9'd192;
      default: return 9'd256;
    endcase
  endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// rtl/spi_sclk_gen.sv - SCLK divider with one-cycle rise/fall strobes, held low while disabled
module spi_sclk_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic sclk,
  output logic rise_tick,
  output logic fall_tick
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] div_cnt;
  logic             half_end;

  // Strobes fire in the cycle whose closing edge moves sclk
  assign half_end  = en && (div_cnt == DIV_W'(CLK_DIV - 1));
  assign rise_tick = half_end && !sclk;
  assign fall_tick = half_end && sclk;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      sclk    <= 1'b0;
    end else if (!en) begin
      div_cnt <= '0;
      sclk    <= 1'b0;
    end else if (half_end) begin
      div_cnt <= '0;
      sclk    <= ~sclk;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_aes_frame_master.sv
// rtl/spi_aes_frame_master.sv - SPI master sending one AES block+key to a selected slave and reading back the result
// Optional SPI_LOOPBACK_EN adds a loopback input that feeds one-period-delayed mosi into the receive path.
module spi_aes_frame_master
  import spi_aes_pkg::*;
#(
  parameter int DATA_W     = 128,
  parameter int N_SLAVES   = 2,
  parameter int CLK_DIV    = 2,
  parameter int TURNAROUND = 4,
  parameter int SEL_W      = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [SEL_W-1:0]    slave_sel,
  input  logic [1:0]          key_len,
  input  logic [DATA_W-1:0]   data_in,
  input  logic [KEY_W-1:0]    key_in,
`ifdef SPI_LOOPBACK_EN
  input  logic                loopback,
`endif
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [DATA_W-1:0]   result,
  output logic                sclk,
  output logic                mosi,
  input  logic [N_SLAVES-1:0] miso,
  output logic [N_SLAVES-1:0] cs_n
);

  localparam int MAX_A   = (DATA_W > KEY_W) ? DATA_W : KEY_W;
  localparam int MAX_B   = (TURNAROUND > CLK_DIV) ? TURNAROUND : CLK_DIV;
  localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int TX_W    = DATA_W + KEY_W;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [SEL_W-1:0]    sel_q;
  logic [1:0]          key_len_q;
  logic [TX_W-1:0]     tx_sr;
  logic [DATA_W-1:0]   rx_sr;
  logic                err_job;
  logic [N_SLAVES-1:0] sel_mask;
  logic                sclk_en;
  logic                rise_tick;
  logic                fall_tick;
  logic                rx_bit;

  always_comb begin
    sel_mask = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (i == int'(slave_sel)) sel_mask[i] = 1'b1;
    end
  end

  // Generator keeps running in DONE only to finish the final high half-period
  assign sclk_en = (state inside {SETUP, SEND_DATA, SEND_KEY, WAIT, RECV}) ||
                   (state == DONE && sclk);

  spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
    .clk       (clk),
    .rst       (rst),
    .en        (sclk_en),
    .sclk      (sclk),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick)
  );

`ifdef SPI_LOOPBACK_EN
  logic lb_q;
  logic mosi_d;
  assign rx_bit = lb_q ? mosi_d : miso[sel_q];
`else
  assign rx_bit = miso[sel_q];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      sel_q     <= '0;
      key_len_q <= '0;
      tx_sr     <= '0;
      rx_sr     <= '0;
      err_job   <= 1'b0;
      mosi      <= 1'b0;
      cs_n      <= '1;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      result    <= '0;
`ifdef SPI_LOOPBACK_EN
      lb_q      <= 1'b0;
      mosi_d    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
`ifdef SPI_LOOPBACK_EN
      if (rise_tick) mosi_d <= mosi;
`endif
      case (state)
        IDLE: begin
          if (start) begin
            busy      <= 1'b1;
            cnt       <= '0;
            sel_q     <= slave_sel;
            key_len_q <= key_len;
            tx_sr     <= {data_in, key_in};
`ifdef SPI_LOOPBACK_EN
            lb_q      <= loopback;
`endif
            if (int'(slave_sel) >= N_SLAVES) begin
              err_job <= 1'b1;
              state   <= DONE;
            end else begin
              err_job <= 1'b0;
              state   <= SETUP;
              mosi    <= data_in[DATA_W-1];
`ifdef SPI_LOOPBACK_EN
              cs_n    <= loopback ? '1 : ~sel_mask;
`else
              cs_n    <= ~sel_mask;
`endif
            end
          end
        end
        // The rise closing SETUP already samples data bit 0
        SETUP: begin
          if (rise_tick) begin
            state <= SEND_DATA;
            cnt   <= CNT_W'(1);
          end
        end
        SEND_DATA: begin
          if (rise_tick) begin
            if (cnt == CNT_W'(DATA_W - 1)) begin
              state <= SEND_KEY;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        SEND_KEY: begin
          if (rise_tick) begin
            if (cnt == CNT_W'(nk_bits(key_len_q) - 9'd1)) begin
              state <= WAIT;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        WAIT: begin
          if (rise_tick) begin
            if (cnt == CNT_W'(TURNAROUND - 1)) begin
              state <= RECV;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        RECV: begin
          if (rise_tick) begin
            rx_sr <= {rx_sr[DATA_W-2:0], rx_bit};
            if (cnt == CNT_W'(DATA_W - 1)) begin
              state <= DONE;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        DONE: begin
          // Wait out the last high half-period, then one low half-period before releasing cs_n
          if (sclk) begin
            cnt <= '0;
          end else if (err_job || cnt == CNT_W'(CLK_DIV - 1)) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            err   <= err_job;
            cs_n  <= '1;
            mosi  <= 1'b0;
            if (!err_job) result <= rx_sr;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
      if (fall_tick) begin
        if (state == SEND_DATA || state == SEND_KEY) begin
          mosi  <= tx_sr[TX_W-2];
          tx_sr <= tx_sr << 1;
        end else begin
          mosi <= 1'b0;
        end
      end
    end
  end

endmodule
